// File: rtl/ws2812b_stream_driver.sv
// rtl/ws2812b_stream_driver.sv - WS2812B pixel-run FIFO driver with bit-timing encoder and deferred latch
module ws2812b_stream_driver #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int T0H_CYC    = 26,
  parameter int T1H_CYC    = 51,
  parameter int TBIT_CYC   = 80,
  parameter int TRST_CYC   = 5120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] uo_out
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int CMAX = (TRST_CYC > TBIT_CYC) ? TRST_CYC : TBIT_CYC;
  localparam int CW   = $clog2(CMAX);

  localparam logic [CW-1:0] C_T0H  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] C_T1H  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] C_TBIT = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] C_TRST = CW'(TRST_CYC - 1);
  localparam logic [LW-1:0] C_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_RST} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_r;
  logic [7:0]      r_g;
  logic [7:0]      r_b;
  logic [6:0]      r_cfg;
  logic            r_ovf;
  logic            r_latch;
  logic [23:0]     r_shift;
  logic [4:0]      r_bit_idx;
  logic [CW-1:0]   r_bitcnt;
  logic [2:0]      r_ch;
  logic [NUM_CH-1:0] r_uo;

  logic            w_empty;
  logic            w_full;
  logic            w_idle;
  logic [31:0]     w_head;
  logic [7:0]      w_head_cnt;
  logic            w_wr_push;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_t_high;
  logic            w_high_done;
  logic            w_bit_done;
  logic            w_pix_done;
  logic            w_rst_done;
  logic [7:0]      w_gs;
  logic [7:0]      w_rs;
  logic [7:0]      w_bs;
  logic [23:0]     w_word;
  logic            w_line;
  logic [2:0]      w_ch;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == C_FULL);
  assign w_idle      = w_empty && (r_state == S_IDLE);
  assign w_head      = r_fifo[r_rd];
  assign w_head_cnt  = w_head[7:0];
  assign w_wr_push   = data_write && (address == 4'h4);
  assign w_push      = w_wr_push && (data_in != 8'h00) && !w_full;
  assign w_t_high    = r_shift[23] ? C_T1H : C_T0H;
  assign w_high_done = (r_state == S_HIGH) && (r_bitcnt == w_t_high);
  assign w_bit_done  = (r_state == S_LOW) && (r_bitcnt == C_TBIT);
  assign w_pix_done  = w_bit_done && (r_bit_idx == 5'd0);
  assign w_pop       = w_pix_done && (w_head_cnt == 8'd1);
  assign w_rst_done  = (r_state == S_RST) && (r_bitcnt == C_TRST);

  assign w_gs   = w_head[31:24] >> r_cfg[6:4];
  assign w_rs   = w_head[23:16] >> r_cfg[6:4];
  assign w_bs   = w_head[15:8]  >> r_cfg[6:4];
  assign w_word = r_cfg[3] ? {w_rs, w_gs, w_bs} : {w_gs, w_rs, w_bs};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Data outranks the latch: a queued run is always streamed before the reset pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty)     w_next = S_LOAD;
        else if (r_latch) w_next = S_RST;
      end
      S_LOAD: w_next = S_HIGH;
      S_HIGH: if (w_high_done) w_next = S_LOW;
      S_LOW: begin
        if (w_bit_done) begin
          if (r_bit_idx != 5'd0)       w_next = S_HIGH;
          else if (w_head_cnt != 8'd1) w_next = S_LOAD;
          else                         w_next = S_IDLE;
        end
      end
      S_RST:   if (w_rst_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The line is registered from the next state so LOAD->HIGH drives high on that same edge.
  always_comb begin
    w_line = (w_next == S_HIGH);
    w_ch   = (r_state == S_LOAD) ? r_cfg[2:0] : r_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uo <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) r_uo[c] <= w_line && (w_ch == 3'(c));
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[NUM_CH-1:0] = r_uo;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= {r_g, r_r, r_b, data_in};
    if (w_pix_done && !w_pop) r_fifo[r_rd][7:0] <= w_head_cnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_level   <= '0;
      r_r       <= 8'h00;
      r_g       <= 8'h00;
      r_b       <= 8'h00;
      r_cfg     <= 7'h00;
      r_ovf     <= 1'b0;
      r_latch   <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= 5'd0;
      r_bitcnt  <= '0;
      r_ch      <= 3'd0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);

      if (data_write) begin
        case (address)
          4'h1:    r_r   <= data_in;
          4'h2:    r_g   <= data_in;
          4'h3:    r_b   <= data_in;
          4'h5:    r_cfg <= data_in[6:0];
          default: ;
        endcase
      end

      if (data_write && address == 4'h7)                    r_ovf <= 1'b0;
      else if (w_wr_push && data_in != 8'h00 && w_full)     r_ovf <= 1'b1;

      if (data_write && address == 4'h6) r_latch <= 1'b1;
      else if (w_rst_done)               r_latch <= 1'b0;

      case (r_state)
        S_LOAD: begin
          r_shift   <= w_word;
          r_ch      <= r_cfg[2:0];
          r_bit_idx <= 5'd23;
          r_bitcnt  <= '0;
        end
        S_HIGH: r_bitcnt <= r_bitcnt + CW'(1);
        S_LOW: begin
          if (w_bit_done) begin
            r_bitcnt <= '0;
            if (r_bit_idx != 5'd0) begin
              r_bit_idx <= r_bit_idx - 5'd1;
              r_shift   <= r_shift << 1;
            end
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
        S_RST:   r_bitcnt <= r_bitcnt + CW'(1);
        default: r_bitcnt <= '0;
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = {4'b0000, r_ovf, r_latch, w_full, w_idle};
      4'h1:    data_out = r_r;
      4'h2:    data_out = r_g;
      4'h3:    data_out = r_b;
      4'h5:    data_out = {1'b0, r_cfg};
      4'h8:    data_out = 8'(r_level);
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_stream_driver.sv
// tb/tb_ws2812b_stream_driver.sv - scoreboard bench for ws2812b_stream_driver
`timescale 1ns/1ps
module tb_ws2812b_stream_driver;
  localparam int NUM_CH = 2;
  localparam int FDEPTH = 4;
  localparam int T0H    = 26;
  localparam int T1H    = 51;
  localparam int TBIT   = 80;
  localparam int TRST   = 5120;
  localparam int PIX    = 24 * TBIT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [7:0] uo_out;

  ws2812b_stream_driver #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FDEPTH), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .data_write(data_write),
    .data_in(data_in), .data_out(data_out), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit b;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_skip = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    address = a; data_in = v; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    address = 4'h0;
    #1;
    while (data_out != 8'h01 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk(name, data_out, 8'h01);
  endtask

  // Reference: each pixel is 24 bits of the shifted, reordered colour, MSB first.
  task automatic model_run(input int ch, input int ord, input int sh,
                           input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                           input int cnt);
    int   comp [3];
    int   val;
    exp_t e;
    if (ch >= NUM_CH) return;
    if (ord != 0) begin comp[0] = r >> sh; comp[1] = g >> sh; end
    else          begin comp[0] = g >> sh; comp[1] = r >> sh; end
    comp[2] = b >> sh;
    val = comp[0] * 65536 + comp[1] * 256 + comp[2];
    for (int p = 0; p < cnt; p++) begin
      for (int i = 23; i >= 0; i--) begin
        e.ch  = ch;
        e.b   = ((val >> i) & 1) == 1;
        e.gap = (i != 23) ? TBIT : ((p == 0) ? 0 : TBIT + 1);
        exp_q.push_back(e);
      end
    end
  endtask

  int cyc = 0, hi_len = 0, pulse_ch = 0, rise_cyc = 0, prev_rise = 0;
  bit in_pulse = 1'b0, have_prev = 1'b0, shape_ok = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_skip) begin
      in_pulse  = 1'b0;
      have_prev = 1'b0;
    end else if (uo_out != 8'h00) begin
      if (!in_pulse) begin
        in_pulse = 1'b1; hi_len = 0; rise_cyc = cyc; shape_ok = 1'b1; pulse_ch = 0;
        for (int c = 7; c >= 0; c--) if (uo_out[c]) pulse_ch = c;
      end
      hi_len++;
      if (uo_out != (8'h01 << pulse_ch)) shape_ok = 1'b0;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pulse_unexpected: ch=%0d len=%0d at cycle %0d, no pulse expected",
                 pulse_ch, hi_len, rise_cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_ch", shape_ok ? pulse_ch : -1, e.ch);
        chk("pulse_len", hi_len, e.b ? T1H : T0H);
        if (e.gap != 0 && have_prev) chk("pulse_gap", rise_cyc - prev_rise, e.gap);
      end
      prev_rise = rise_cyc;
      have_prev = 1'b1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, g, r, b, cfg;
    int n, ch, ord, sh, cnt;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out, 0);
    rst = 1'b0;
    mon_skip = 1'b0;
    rd(4'h0, d); chk("rst_status", d, 8'h01);
    rd(4'h8, d); chk("rst_level", d, 0);
    rd(4'h5, d); chk("rst_cfg", d, 0);
    rd(4'h2, d); chk("rst_g", d, 0);
    rd(4'h9, d); chk("unmapped", d, 0);
    wr(4'h4, 8'h00);
    rd(4'h8, d); chk("push0_level", d, 0);

    // single pixel G=80 R=00 B=01 with push-to-line latency
    wr(4'h1, 8'h00); wr(4'h2, 8'h80); wr(4'h3, 8'h01);
    model_run(0, 0, 0, 8'h80, 8'h00, 8'h01, 1);
    wr(4'h4, 8'h01);
    @(negedge clk); chk("lat_n1", uo_out, 0);
    @(negedge clk); chk("lat_n2", uo_out, 1);
    repeat (PIX - 2) @(negedge clk);
    rd(4'h0, d); chk("t1_busy", d[0], 0);
    @(negedge clk);
    rd(4'h0, d); chk("t1_idle", d, 8'h01);

    // three-pixel run then deferred latch
    g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
    wr(4'h1, r); wr(4'h2, g); wr(4'h3, b);
    model_run(0, 0, 0, g, r, b, 3);
    wr(4'h4, 8'h03);
    wr(4'h6, 8'h01);
    rd(4'h0, d); chk("t2_pending", d, 8'h04);
    wr(4'h6, 8'hFF);
    address = 4'h0; #1;
    n = 0;
    while (data_out != 8'h05 && n < 3 * PIX + 100) begin @(negedge clk); #1; n++; end
    chk("t2_drain", data_out, 8'h05);
    n = 0;
    @(negedge clk); #1;
    while (data_out == 8'h04 && n < TRST + 100) begin n++; @(negedge clk); #1; end
    chk("t2_rst_len", n, TRST);
    chk("t2_after", data_out, 8'h01);

    // overflow on a channel with no line
    wr(4'h5, 8'h07);
    for (int k = 0; k < 5; k++) wr(4'h4, 8'h01);
    rd(4'h8, d); chk("t3_level", d, 4);
    rd(4'h0, d); chk("t3_status", d, 8'h0A);
    wr(4'h7, 8'h00);
    rd(4'h0, d); chk("t3_clr", d, 8'h02);
    wait_idle(4 * (PIX + 1) + 100, "t3_drain");

    // RGB order with brightness shift 1
    wr(4'h5, 8'h18); wr(4'h1, 8'hFF); wr(4'h2, 8'h00); wr(4'h3, 8'h02);
    rd(4'h5, d); chk("t4_cfg", d, 8'h18);
    model_run(0, 1, 1, 8'h00, 8'hFF, 8'h02, 1);
    wr(4'h4, 8'h01);
    wait_idle(PIX + 100, "t4_drain");

    // channel change mid-pixel moves only the next pixel
    wr(4'h5, 8'h00);
    g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
    wr(4'h1, r); wr(4'h2, g); wr(4'h3, b);
    model_run(0, 0, 0, g, r, b, 1);
    model_run(1, 0, 0, g, r, b, 1);
    wr(4'h4, 8'h02);
    repeat (900) @(negedge clk);
    wr(4'h5, 8'h01);
    wait_idle(2 * PIX + 100, "t5_drain");

    // randomized configurations and colours
    for (int k = 0; k < 4; k++) begin
      ch  = $urandom_range(0, NUM_CH - 1);
      ord = $urandom_range(0, 1);
      sh  = $urandom_range(0, 7);
      cnt = $urandom_range(1, 2);
      g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
      cfg = 8'(ch) | (8'(ord) << 3) | (8'(sh) << 4);
      wr(4'h5, cfg); wr(4'h1, r); wr(4'h2, g); wr(4'h3, b);
      rd(4'h1, d); chk("rnd_r", d, r);
      model_run(ch, ord, sh, g, r, b, cnt);
      wr(4'h4, 8'(cnt));
      wait_idle(cnt * PIX + 100, "rnd_drain");
    end

    // reset in the middle of a high phase
    mon_skip = 1'b1;
    wr(4'h5, 8'h00); wr(4'h2, 8'hAA); wr(4'h4, 8'h02);
    n = 0;
    while (!uo_out[0] && n < 200) begin @(negedge clk); n++; end
    chk("t6_high", uo_out[0], 1);
    repeat (5) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_uo", uo_out, 0);
    rst = 1'b0;
    rd(4'h8, d); chk("t6_level", d, 0);
    rd(4'h0, d); chk("t6_status", d, 8'h01);
    rd(4'h2, d); chk("t6_g", d, 0);
    @(negedge clk);
    mon_skip = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_quiet", uo_out, 0);

    chk("exp_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
